hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Control counterpart of the decode/execute pipeline register. It reads the E-stage fields that register produces, plus M/W writeback info.
- It drives the register's clear input (FlushE), the new stall enables, and the forwarding muxes.
- It adds a multi-cycle divide stall FSM, so a DIV/REM holds the E stage for DIV_LAT cycles.

Parameters:
DIV_LAT, 4, total cycles a DIV/DIVU/REM/REMU occupies E; legal range 2..16
CNT_W, 4, width of the busy counter; must hold DIV_LAT-2

Ports:
clk  in  1  clock; state updates on negedge clk, matching the pipeline registers
reset_n  in  1  asynchronous, active-low reset
Rs1D  in  5  decode source register 1
Rs2D  in  5  decode source register 2
Rs1E  in  5  execute source register 1
Rs2E  in  5  execute source register 2
RdE  in  5  execute destination register
ResultSrcE0  in  1  E-stage instruction is a load
PCSrcE  in  1  taken branch/jump resolved in E
OpE  in  7  E-stage opcode
Funct7E  in  7  E-stage funct7
Funct3E  in  3  E-stage funct3
RdM  in  5  memory-stage destination register
RegWriteM  in  1  memory-stage register write enable
RdW  in  5  writeback-stage destination register
RegWriteW  in  1  writeback-stage register write enable
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register (drives its clear input)
FlushM  out  1  clear EX/MEM register (bubble)
ForwardAE  out  2  ALU operand A select: 00 register file, 01 W result, 10 M ALU result
ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE
BusyE  out  1  multi-cycle stall active (equals mcStall)

Behaviour:
- Reset (reset_n=0):
  - Async entry to IDLE; cnt=0.
  - Every output is forced to 0 while reset_n is low, regardless of inputs.
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- Load-use: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- divE = (OpE==7'b0110011) && (Funct7E==7'b0000001) && Funct3E[2].
- FSM states: IDLE, BUSY, DONE. cnt is CNT_W bits.
  - IDLE: mcStall = divE.
    - If divE and DIV_LAT==2: go to DONE.
    - If divE and DIV_LAT>2: go to BUSY, cnt=DIV_LAT-2.
    - Otherwise stay in IDLE.
  - BUSY: mcStall=1. If cnt==1 go to DONE, else cnt=cnt-1.
  - DONE: mcStall=0 and divE is ignored, because the same divide is still in E and leaves at this edge. Next state IDLE unconditionally.
  - Net effect: a divide asserts mcStall for exactly DIV_LAT-1 consecutive cycles, then one free cycle.
  - Back-to-back divides re-trigger from IDLE.
- Output equations:
  - StallF = StallD = lwStall | mcStall
  - StallE = FlushM = BusyE = mcStall
  - FlushD = PCSrcE & ~mcStall
  - FlushE = (lwStall | PCSrcE) & ~mcStall
- Priority: mcStall overrides lwStall and PCSrcE. The E instruction must be preserved while held. A divide is never a branch, so a simultaneous PCSrcE is not expected, but the priority still applies.
- Latency: outputs other than the FSM state are combinational, zero-cycle. The FSM adds no delay on the first divide cycle, because the IDLE decode is combinational.
- Reset mid-operation: an in-progress count is discarded. If a divide is still in E after release, IDLE re-triggers a full DIV_LAT-1 stall.

Test Plan:
- Forwarding:
  - RegWriteM=1 RdM=5, RegWriteW=1 RdW=5, Rs1E=5 -> ForwardAE=10.
  - Set RegWriteM=0 -> ForwardAE=01.
  - Rs1E=RdM=0 with RegWriteM=1 -> ForwardAE=00.
  - Repeat on Rs2E/ForwardBE.
- Load-use:
  - ResultSrcE0=1 RdE=7 Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0, StallE=0.
  - Same with RdE=0 -> all 0.
- Taken branch: PCSrcE=1, no load -> FlushD=FlushE=1, StallF=StallD=0.
- DIV_LAT=4, DIV (funct3=100, funct7=0000001) held in E:
  - StallF/D/E, FlushM and BusyE are 1 for 3 consecutive cycles, then 0 on the 4th (DONE).
  - Then IDLE.
- Two back-to-back divides -> stall pattern 1,1,1,0,1,1,1,0. MUL (funct3=000) -> no stall.
- reset_n pulsed low during BUSY (cnt=1):
  - All outputs go to 0 immediately.
  - After release with the divide still in E, a full 3-cycle stall repeats.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: forwarding, load-use stall, branch flush, divide stall FSM
module hazard_ctrl #(
    parameter int DIV_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic [6:0] OpE,
    input  logic [6:0] Funct7E,
    input  logic [2:0] Funct3E,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       BusyE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // First stall cycle comes from the combinational IDLE decode, the last
    // cycle is the free DONE cycle, so the counter only covers the middle.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             div_e;
    logic             lw_stall;
    logic             mc_stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // Low funct3 bits do not distinguish DIV/DIVU/REM/REMU from other M ops
    logic unused_funct3;
    assign unused_funct3 = ^Funct3E[1:0];

    assign div_e    = (OpE == 7'b0110011) && (Funct7E == 7'b0000001) && Funct3E[2];
    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Operand A forwarding select, memory stage wins over writeback
    always_comb begin
        fwd_a = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            fwd_a = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            fwd_a = 2'b01;
        end
    end

    // Operand B forwarding select, same priority as operand A
    always_comb begin
        fwd_b = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            fwd_b = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            fwd_b = 2'b01;
        end
    end

    // Stall request from the divide FSM; DONE ignores divE since the same divide is leaving E
    always_comb begin
        mc_stall = 1'b0;
        case (state)
            IDLE:    mc_stall = div_e;
            BUSY:    mc_stall = 1'b1;
            default: mc_stall = 1'b0;
        endcase
    end

    // Divide occupancy FSM, updated on the falling edge alongside the pipeline registers
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_e) begin
                        if (DIV_LAT == 2) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CNT_ONE) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output stage: the divide stall overrides load-use and branch flushes; all outputs are zero in reset
    always_comb begin
        StallF    = reset_n & (lw_stall | mc_stall);
        StallD    = reset_n & (lw_stall | mc_stall);
        StallE    = reset_n & mc_stall;
        FlushM    = reset_n & mc_stall;
        BusyE     = reset_n & mc_stall;
        FlushD    = reset_n & PCSrcE & ~mc_stall;
        FlushE    = reset_n & (lw_stall | PCSrcE) & ~mc_stall;
        ForwardAE = reset_n ? fwd_a : 2'b00;
        ForwardBE = reset_n ? fwd_b : 2'b00;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int DIV_LAT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
    logic [6:0] OpE, Funct7E;
    logic [2:0] Funct3E;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;
    logic [1:0] ForwardAE, ForwardBE;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // model state: stall cycles already spent on the current divide, and the free cycle flag
    int held = 0;
    bit free_cyc = 1'b0;

    hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .OpE(OpE), .Funct7E(Funct7E), .Funct3E(Funct3E),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusyE(BusyE)
    );

    always #5 clk = ~clk;

    function automatic bit is_div();
        return (OpE == 7'h33) && (Funct7E == 7'h01) && (Funct3E inside {3'd4, 3'd5, 3'd6, 3'd7});
    endfunction

    function automatic bit model_mc();
        if (free_cyc) return 1'b0;
        return (held > 0) || is_div();
    endfunction

    function automatic int model_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    // model of divide occupancy advances with the design's falling-edge state
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held = 0;
            free_cyc = 1'b0;
        end else if (free_cyc) begin
            free_cyc = 1'b0;
        end else if (model_mc()) begin
            held++;
            if (held == DIV_LAT - 1) begin
                held = 0;
                free_cyc = 1'b1;
            end
        end
    end

    // every-cycle comparison against the model
    always @(posedge clk) begin
        bit mc, lw, r;
        #4;
        cycle++;
        r  = reset_n;
        mc = model_mc();
        lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        check("StallF", StallF, r & (lw | mc));
        check("StallD", StallD, r & (lw | mc));
        check("StallE", StallE, r & mc);
        check("FlushM", FlushM, r & mc);
        check("BusyE",  BusyE,  r & mc);
        check("FlushD", FlushD, r & PCSrcE & !mc);
        check("FlushE", FlushE, r & (lw | PCSrcE) & !mc);
        check("ForwardAE", ForwardAE, r ? model_fwd(Rs1E) : 0);
        check("ForwardBE", ForwardBE, r ? model_fwd(Rs2E) : 0);
    end

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        OpE = 7'h13; Funct7E = 0; Funct3E = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input logic [2:0] f3);
        OpE = 7'b0110011; Funct7E = 7'b0000001; Funct3E = f3;
    endtask

    initial begin
        logic [7:0] pat;
        clear_inputs();
        // reset with busy-looking inputs: everything must read zero
        next_cycle();
        RegWriteM = 1; RdM = 5; Rs1E = 5; PCSrcE = 1; set_div(3'b100);
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        #2;
        check("lit_reset_StallF", StallF, 0);
        check("lit_reset_FlushE", FlushE, 0);
        check("lit_reset_FwdA", ForwardAE, 0);
        next_cycle();
        clear_inputs();
        reset_n = 1;

        // forwarding on operand A
        next_cycle();
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
        #2 check("lit_fwdA_M", ForwardAE, 2'b10);
        next_cycle();
        RegWriteM = 0;
        #2 check("lit_fwdA_W", ForwardAE, 2'b01);
        next_cycle();
        RegWriteM = 1; RdM = 0; Rs1E = 0; RdW = 0;
        #2 check("lit_fwdA_x0", ForwardAE, 2'b00);

        // forwarding on operand B
        next_cycle();
        clear_inputs();
        RegWriteM = 1; RdM = 9; RegWriteW = 1; RdW = 9; Rs2E = 9;
        #2 check("lit_fwdB_M", ForwardBE, 2'b10);
        next_cycle();
        RegWriteM = 0;
        #2 check("lit_fwdB_W", ForwardBE, 2'b01);
        next_cycle();
        RegWriteM = 1; RdM = 0; Rs2E = 0; RdW = 0;
        #2 check("lit_fwdB_x0", ForwardBE, 2'b00);

        // load-use
        next_cycle();
        clear_inputs();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        #2;
        check("lit_lw_StallF", StallF, 1);
        check("lit_lw_FlushE", FlushE, 1);
        check("lit_lw_FlushD", FlushD, 0);
        check("lit_lw_StallE", StallE, 0);
        next_cycle();
        RdE = 0; Rs2D = 0;
        #2 check("lit_lw_x0_StallF", StallF, 0);

        // taken branch
        next_cycle();
        clear_inputs();
        PCSrcE = 1;
        #2;
        check("lit_br_FlushD", FlushD, 1);
        check("lit_br_FlushE", FlushE, 1);
        check("lit_br_StallF", StallF, 0);

        // single divide followed by an idle cycle
        next_cycle();
        clear_inputs();
        set_div(3'b100);
        pat = 8'b1110_0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            #2 check("lit_div1_BusyE", BusyE, pat[7-i]);
        end
        next_cycle();
        clear_inputs();
        #2 check("lit_div1_idle", StallE, 0);

        // back-to-back divides held in E for 8 cycles
        pat = 8'b1110_1110;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            set_div(3'b110);
            ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
            #2;
            check("lit_b2b_StallF", StallF, 1);
            check("lit_b2b_StallE", StallE, pat[7-i]);
        end

        // MUL never stalls
        next_cycle();
        clear_inputs();
        set_div(3'b000);
        #2 check("lit_mul_StallE", StallE, 0);
        next_cycle();
        #2 check("lit_mul_StallE2", StallE, 0);

        // reset during the last BUSY cycle, then a full restall
        next_cycle();
        set_div(3'b101);
        next_cycle();
        next_cycle();
        #2 check("lit_rst_pre", BusyE, 1);
        reset_n = 0;
        #1;
        check("lit_rst_StallF", StallF, 0);
        check("lit_rst_BusyE", BusyE, 0);
        pat = 8'b1110_0000;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            reset_n = 1;
            #2 check("lit_rst_restall", BusyE, pat[7-i]);
        end

        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
